uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - buffered 8N1 UART transmitter with byte FIFO front end
// Bytes are queued in a small FIFO; the TX FSM drains it back to back with no idle gap.

module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DEPTH        = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [8:0] wr_opt_byte,
  output logic       wr_ready,
  output logic       line_out,
  output logic       busy
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            line_d;
  logic            baud_end;

  logic                    push;
  logic                    pop;
  logic [7:0]              head;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;

  // Ready depends only on occupancy (and reset), never on the write argument.
  assign wr_ready = !RST && !full;
  assign push     = wr_ready && wr_opt_byte[8];

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push),
    .push_data (wr_opt_byte[7:0]),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign baud_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // The line level is derived from the next state so it can be registered.
    line_d = 1'b1;
    if (state_d == START)     line_d = 1'b0;
    else if (state_d == DATA) line_d = shift_d[0];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      line_out <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      line_out <= line_d;
    end
  end

  assign busy = (state_q != IDLE) || (count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx with a serial-decoding monitor

module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       CLK;
  logic       RST;
  logic [8:0] wr_opt_byte;
  logic       wr_ready;
  logic       line_out;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         frame_starts[$];

  uart_tx #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .wr_opt_byte (wr_opt_byte),
    .wr_ready    (wr_ready),
    .line_out    (line_out),
    .busy        (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Serial monitor: captures one sample per bit-cycle and decodes a full frame.
  int   pos = -1;
  logic samp [FRAME];

  task automatic check_frame();
    logic       ok_start, ok_stop, ok_bits;
    logic [7:0] b;
    ok_start = 1'b1;
    ok_stop  = 1'b1;
    ok_bits  = 1'b1;
    for (int i = 0; i < CPB; i++) if (samp[i] !== 1'b0) ok_start = 1'b0;
    for (int i = 9 * CPB; i < FRAME; i++) if (samp[i] !== 1'b1) ok_stop = 1'b0;
    for (int k = 0; k < 8; k++) begin
      b[k] = samp[CPB + CPB * k];
      for (int j = 1; j < CPB; j++)
        if (samp[CPB + CPB * k + j] !== b[k]) ok_bits = 1'b0;
    end
    chk("start_bit", ok_start, 1);
    chk("stop_bit", ok_stop, 1);
    chk("bit_timing", ok_bits, 1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame: got byte %0h expected no frame", b);
    end else begin
      chk("frame_byte", b, exp_q.pop_front());
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      pos = -1;
      exp_q.delete();
    end else begin
      if (pos < 0 && line_out == 1'b0) begin
        pos = 0;
        frame_starts.push_back(cyc);
      end
      if (pos >= 0) begin
        samp[pos] = line_out;
        pos++;
        if (pos == FRAME) begin
          check_frame();
          pos = -1;
        end
      end
    end
  end

  // Called just after a negedge; returns at the following negedge.
  task automatic drive_cycle(input logic v, input logic [7:0] b, output logic acc);
    wr_opt_byte = {v, b};
    acc = v && wr_ready && !RST;
    if (acc) exp_q.push_back(b);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'($urandom), acc);
  endtask

  task automatic send(input logic [7:0] b);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 200) begin
      drive_cycle(1'b1, b, acc);
      n++;
    end
    wr_opt_byte = 9'h000;
    chk("send_accept", acc, 1);
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      drive_cycle(1'b0, 8'h00, acc);
      n++;
    end
    chk("drain_done", (exp_q.size() == 0 && !busy), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    RST = 1'b1;
    wr_opt_byte = 9'h000;
    #1;
    chk("rst_line", line_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ready", wr_ready, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("post_rst_ready", wr_ready, 1);
    chk("post_rst_busy", busy, 0);
    @(negedge CLK);

    // Single 0x55 frame: latency and busy timing.
    drive_cycle(1'b1, 8'h55, acc);
    wr_opt_byte = 9'h000;
    chk("accept_55", acc, 1);
    chk("line_at_E", line_out, 1);
    chk("busy_at_E", busy, 1);
    @(negedge CLK);
    chk("line_fall_E1", line_out, 0);
    repeat (39) @(negedge CLK);
    chk("busy_E40", busy, 1);
    @(negedge CLK);
    chk("busy_E41", busy, 0);
    drain();

    // Back-to-back frames.
    frame_starts.delete();
    drive_cycle(1'b1, 8'hA3, acc);
    chk("accept_A3", acc, 1);
    drive_cycle(1'b1, 8'h0F, acc);
    chk("accept_0F", acc, 1);
    drain();
    chk("b2b_frames", frame_starts.size(), 2);
    if (frame_starts.size() == 2)
      chk("b2b_gap", frame_starts[1] - frame_starts[0], FRAME);

    // Valid held for 10 cycles: FIFO saturates after 5 accepts.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, 8'h41, acc);
      if (acc) n++;
    end
    wr_opt_byte = 9'h000;
    chk("hold_accepts", n, 5);
    chk("hold_full_ready", wr_ready, 0);
    drain();

    // Invalid writes are ignored.
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 8'hFF, acc);
      chk("novalid_line", line_out, 1);
      chk("novalid_busy", busy, 0);
    end

    // Reset mid-frame with bytes buffered.
    drive_cycle(1'b1, 8'h00, acc);
    drive_cycle(1'b1, 8'h22, acc);
    drive_cycle(1'b1, 8'h33, acc);
    wr_opt_byte = 9'h000;
    repeat (12) @(negedge CLK);
    chk("midframe_line_low", line_out, 0);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_line", line_out, 1);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_ready", wr_ready, 0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("rel_ready", wr_ready, 1);
    chk("rel_busy", busy, 0);
    @(negedge CLK);
    for (int i = 0; i < 100; i++) begin
      drive_cycle(1'b0, 8'h00, acc);
      chk("after_rst_line", line_out, 1);
      chk("after_rst_busy", busy, 0);
    end

    // Random traffic with random gaps.
    for (int i = 0; i < 1000; i++) begin
      send(8'($urandom));
      if ($urandom_range(0, 9) == 0) idle($urandom_range(40, 120));
      else idle($urandom_range(0, 2));
    end
    drain();
    chk("final_line", line_out, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
